branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side counterpart to EX-stage branch resolution.
- Predicts taken/target for the IF-stage PC using a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Consumes resolved branch/jump outcomes from EX, trains the table, and detects mispredictions.
- Issues a registered redirect/flush to the PC logic and keeps branch and mispredict statistics counters.

Parameters:
- XLEN, 32, datapath/PC width (matches defs.vh).
- ENTRIES, 16, BTB entry count; power of two, >= 2.
- INDEX_BITS, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock, synchronous, active-high.
- fetch_pc  input  XLEN  PC being fetched in IF.
- pred_taken  output  1  prediction for fetch_pc (combinational from table state).
- pred_target  output  XLEN  predicted next PC; fetch_pc+4 when not taken.
- ex_valid  input  1  EX instruction valid this cycle.
- ex_is_branch  input  1  conditional branch (beq/bne/blt/bge/bltu/bgeu).
- ex_is_jump  input  1  jal or jalr.
- ex_pc  input  XLEN  PC of the EX instruction.
- ex_taken  input  1  resolved taken (1 for jumps).
- ex_target  input  XLEN  resolved target.
- ex_pred_taken  input  1  pred_taken carried down the pipe with this instruction.
- ex_pred_target  input  XLEN  pred_target carried down the pipe with this instruction.
- redirect_valid  output  1  one-cycle pulse: load redirect_pc, flush IF/ID and ID/EX.
- redirect_pc  output  XLEN  corrected PC.
- branch_count  output  32  resolved branches + jumps.
- mispredict_count  output  32  mispredictions.

Behaviour:
- Address fields: index = pc[INDEX_BITS+1:2]; tag = pc[XLEN-1:INDEX_BITS+2].
- Entry contents: valid, tag, target (XLEN), ctr (2 bits), jmp (1 bit).
- Lookup: hit = valid && tag match.
  - pred_taken = hit && (jmp || ctr[1]).
  - pred_target = pred_taken ? entry.target : fetch_pc+4.
  - Zero latency; reads pre-edge state.
  - A same-cycle update to the same index is not visible until the next cycle.
- Resolve event: ex_valid && !redirect_valid. When redirect_valid is high, the EX instruction is wrong-path: no table update, no counter increments, no new redirect.
- Update on a resolve event with (ex_is_branch || ex_is_jump):
  - Hit, branch: ctr saturating +1 if taken, else saturating -1 (11 stays 11, 00 stays 00); target <= ex_target if taken.
  - Hit, jump: target <= ex_target; ctr untouched.
  - Miss and taken: allocate/overwrite. valid=1, tag, target=ex_target, ctr=2'b10, jmp=ex_is_jump.
  - Miss and not taken: no allocation.
- Resolve event on a non-branch/non-jump with ex_pred_taken=1 (alias): invalidate the entry at ex_pc's index if its tag matches.
- Mispredict, evaluated on resolve events only:
  - Control-flow instruction: ex_taken != ex_pred_taken, OR (ex_taken && ex_target != ex_pred_target).
  - Non-control-flow instruction: ex_pred_taken=1.
- Redirect:
  - Registered; redirect_valid rises the cycle after the mispredicting resolve and is high for exactly 1 cycle.
  - redirect_pc = (control-flow && ex_taken) ? ex_target : ex_pc+4.
  - redirect_pc holds its last value while redirect_valid=0.
- Counters:
  - branch_count +1 per control-flow resolve event; mispredict_count +1 per mispredict.
  - Both update at the same edge as the table and saturate at 32'hFFFFFFFF.
- Arithmetic: all +4 additions are modulo 2^XLEN (0xFFFFFFFC+4 = 0).
- Reset (synchronous; overrides all other activity, including mid-redirect):
  - All valid bits cleared; ctr, target, tag and jmp cleared.
  - redirect_valid=0, redirect_pc=0, both counters=0.
  - With no hit, pred_taken=0 and pred_target=fetch_pc+4.

Test Plan:
- Reset, then fetch_pc=0x100 -> pred_taken=0, pred_target=0x104; redirect_valid=0; counters 0.
- Resolve beq, ex_pc=0x100, taken, ex_target=0x80, ex_pred_taken=0 -> next cycle redirect_valid=1, redirect_pc=0x80, mispredict_count=1, branch_count=1; following cycle redirect_valid=0. Then fetch_pc=0x100 -> pred_taken=1, pred_target=0x80.
- Continuing from the previous case, resolve 0x100 not taken with ex_pred_taken=1 -> redirect_pc=0x104; ctr 10->01; fetch_pc=0x100 -> pred_taken=0. Next taken resolve -> ctr 10. Four more taken resolves -> ctr holds at 11.
- Alias: fetch_pc=0x140 (same index as 0x100, different tag) -> pred_taken=0. Resolve jal at 0x140, target 0x300 -> entry replaced; three resolves of jal -> pred_taken stays 1 regardless of ctr.
- Non-branch at 0x140 with ex_pred_taken=1 -> redirect_pc=0x144; entry invalidated; fetch_pc=0x140 -> pred_taken=0; branch_count unchanged.
- Mispredict followed by ex_valid=1 (mispredicting) in the redirect_valid cycle -> no second redirect, counters and table unchanged. Assert rst during redirect_valid=1 -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: predicts for the fetch PC, trains on resolved
// EX outcomes, and issues a registered one-cycle redirect on a mispredict.
module branch_predictor #(
    parameter  int XLEN       = 32,
    parameter  int ENTRIES    = 16,
    localparam int INDEX_BITS = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);
    localparam int TAG_W = XLEN - INDEX_BITS - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [1:0]       ctr;
        logic             jmp;
    } entry_t;

    entry_t                  btb_q [ENTRIES];
    entry_t                  wr_d;
    logic                    wr_en;
    logic                    redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]         redirect_pc_q, redirect_pc_d;
    logic [31:0]             branch_cnt_q, branch_cnt_d;
    logic [31:0]             mispred_cnt_q, mispred_cnt_d;

    logic [INDEX_BITS-1:0]   f_idx, ex_idx;
    logic [TAG_W-1:0]        f_tag, ex_tag;
    entry_t                  f_ent, ex_ent;
    logic                    f_hit, ex_hit, resolve, is_cf, mispredict;
    logic                    unused_lsbs;

    assign unused_lsbs = ^{fetch_pc[1:0], ex_pc[1:0]};

    // Fetch lookup reads pre-edge table state only.
    assign f_idx       = fetch_pc[INDEX_BITS+1:2];
    assign f_tag       = fetch_pc[XLEN-1:INDEX_BITS+2];
    assign f_ent       = btb_q[f_idx];
    assign f_hit       = f_ent.valid && (f_ent.tag == f_tag);
    assign pred_taken  = f_hit && (f_ent.jmp || f_ent.ctr[1]);
    assign pred_target = pred_taken ? f_ent.target : fetch_pc + XLEN'(4);

    assign ex_idx  = ex_pc[INDEX_BITS+1:2];
    assign ex_tag  = ex_pc[XLEN-1:INDEX_BITS+2];
    assign ex_ent  = btb_q[ex_idx];
    assign ex_hit  = ex_ent.valid && (ex_ent.tag == ex_tag);
    // The instruction in EX during a redirect cycle is wrong-path and is ignored.
    assign resolve = ex_valid && !redirect_valid_q;
    assign is_cf   = ex_is_branch || ex_is_jump;

    always_comb begin
        wr_en = 1'b0;
        wr_d  = ex_ent;
        if (resolve) begin
            if (is_cf) begin
                if (ex_hit) begin
                    wr_en = 1'b1;
                    if (ex_is_jump) begin
                        wr_d.target = ex_target;
                    end else if (ex_taken) begin
                        wr_d.target = ex_target;
                        if (ex_ent.ctr != 2'b11) wr_d.ctr = ex_ent.ctr + 2'd1;
                    end else if (ex_ent.ctr != 2'b00) begin
                        wr_d.ctr = ex_ent.ctr - 2'd1;
                    end
                end else if (ex_taken) begin
                    wr_en = 1'b1;
                    wr_d  = '{valid: 1'b1, tag: ex_tag, target: ex_target,
                              ctr: 2'b10, jmp: ex_is_jump};
                end
            end else if (ex_pred_taken && ex_hit) begin
                wr_en       = 1'b1;
                wr_d.valid  = 1'b0;
            end
        end
    end

    always_comb begin
        mispredict = 1'b0;
        if (resolve) begin
            if (is_cf)
                mispredict = (ex_taken != ex_pred_taken) ||
                             (ex_taken && (ex_target != ex_pred_target));
            else
                mispredict = ex_pred_taken;
        end
        redirect_valid_d = mispredict;
        redirect_pc_d    = redirect_pc_q;
        if (mispredict)
            redirect_pc_d = (is_cf && ex_taken) ? ex_target : ex_pc + XLEN'(4);
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve && is_cf && branch_cnt_q != 32'hFFFF_FFFF)
            branch_cnt_d = branch_cnt_q + 32'd1;
        if (mispredict && mispred_cnt_q != 32'hFFFF_FFFF)
            mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            if (wr_en) btb_q[ex_idx] <= wr_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
        end
    end

    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: vector table for resolve/train steps, redirect PCs
// checked through a scoreboard queue, hand sequences for wrong-path and reset corners.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc, branch_count, mispredict_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, br, jp;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt, fpc;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic        e_pt;
        logic [31:0] e_ptgt, e_bc, e_mc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic v, logic br, logic jp, logic [31:0] pc, logic tk,
                                logic [31:0] tgt, logic ptk, logic [31:0] ptgt,
                                logic [31:0] fpc, logic e_rv, logic [31:0] e_rpc,
                                logic e_pt, logic [31:0] e_ptgt, logic [31:0] e_bc,
                                logic [31:0] e_mc);
        vec_t t;
        t.v = v; t.br = br; t.jp = jp; t.pc = pc; t.tk = tk; t.tgt = tgt;
        t.ptk = ptk; t.ptgt = ptgt; t.fpc = fpc; t.e_rv = e_rv; t.e_rpc = e_rpc;
        t.e_pt = e_pt; t.e_ptgt = e_ptgt; t.e_bc = e_bc; t.e_mc = e_mc;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Every redirect pulse must match the oldest outstanding expected PC.
    always @(negedge clk) begin
        if (redirect_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_redirect", redirect_pc, 32'hxxxx_xxxx);
            end else begin
                chk("redirect_pc", redirect_pc, sb.pop_front());
            end
        end
    end

    task automatic drive(logic v, logic br, logic jp, logic [31:0] pc, logic tk,
                         logic [31:0] tgt, logic ptk, logic [31:0] ptgt);
        ex_valid = v; ex_is_branch = br; ex_is_jump = jp; ex_pc = pc;
        ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    task automatic run(input vec_t t, input int n);
        drive(t.v, t.br, t.jp, t.pc, t.tk, t.tgt, t.ptk, t.ptgt);
        fetch_pc = t.fpc;
        if (t.e_rv) sb.push_back(t.e_rpc);
        @(negedge clk);
        chk($sformatf("v%0d_rv", n), 32'(redirect_valid), 32'(t.e_rv));
        chk($sformatf("v%0d_bc", n), branch_count, t.e_bc);
        chk($sformatf("v%0d_mc", n), mispredict_count, t.e_mc);
        ex_valid = 1'b0;
        #1;
        chk($sformatf("v%0d_pt", n), 32'(pred_taken), 32'(t.e_pt));
        chk($sformatf("v%0d_ptgt", n), pred_target, t.e_ptgt);
        @(negedge clk);
        chk($sformatf("v%0d_rv_clr", n), 32'(redirect_valid), 32'd0);
    endtask

    initial begin
        //            v  br jp pc            tk tgt     ptk ptgt    fpc          rv rpc     pt tgt     bc  mc
        vq.push_back(mk(1, 1, 0, 32'h100,    1, 32'h80,  0, 32'h104, 32'h100,    1, 32'h80,  1, 32'h80,  1,  1));
        vq.push_back(mk(1, 1, 0, 32'h100,    0, 32'h80,  1, 32'h80,  32'h100,    1, 32'h104, 0, 32'h104, 2,  2));
        vq.push_back(mk(1, 1, 0, 32'h100,    1, 32'h80,  0, 32'h104, 32'h100,    1, 32'h80,  1, 32'h80,  3,  3));
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(1, 1, 0, 32'h100, 1, 32'h80, 1, 32'h80, 32'h100, 0, 0, 1, 32'h80, 4 + i, 3));
        vq.push_back(mk(1, 1, 0, 32'h100,    0, 32'h80,  1, 32'h80,  32'h100,    1, 32'h104, 1, 32'h80,  8,  4));
        vq.push_back(mk(1, 1, 0, 32'h100,    0, 32'h80,  1, 32'h80,  32'h100,    1, 32'h104, 0, 32'h104, 9,  5));
        vq.push_back(mk(1, 1, 0, 32'h100,    0, 32'h80,  0, 32'h104, 32'h100,    0, 0,       0, 32'h104, 10, 5));
        vq.push_back(mk(1, 1, 0, 32'h100,    0, 32'h80,  0, 32'h104, 32'h100,    0, 0,       0, 32'h104, 11, 5));
        vq.push_back(mk(1, 1, 0, 32'h100,    1, 32'h80,  0, 32'h104, 32'h100,    1, 32'h80,  0, 32'h104, 12, 6));
        vq.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,   0, 32'h0,   32'h140,    0, 0,       0, 32'h144, 12, 6));
        vq.push_back(mk(1, 0, 1, 32'h140,    1, 32'h300, 0, 32'h144, 32'h140,    1, 32'h300, 1, 32'h300, 13, 7));
        vq.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,   0, 32'h0,   32'h100,    0, 0,       0, 32'h104, 13, 7));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1, 0, 1, 32'h140, 1, 32'h300, 1, 32'h300, 32'h140, 0, 0, 1, 32'h300, 14 + i, 7));
        vq.push_back(mk(1, 0, 1, 32'h140,    1, 32'h380, 1, 32'h300, 32'h140,    1, 32'h380, 1, 32'h380, 17, 8));
        vq.push_back(mk(1, 0, 0, 32'h140,    0, 32'h0,   1, 32'h380, 32'h140,    1, 32'h144, 0, 32'h144, 17, 9));
        vq.push_back(mk(1, 1, 0, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h10, 32'hFFFF_FFFC, 1, 32'h0, 0, 32'h0,   18, 10));
        vq.push_back(mk(1, 0, 0, 32'h200,    0, 32'h0,   0, 32'h204, 32'h200,    0, 0,       0, 32'h204, 18, 10));

        rst = 1'b1;
        fetch_pc = 32'h100;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pt", 32'(pred_taken), 32'd0);
        chk("rst_ptgt", pred_target, 32'h104);
        chk("rst_rv", 32'(redirect_valid), 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_bc", branch_count, 32'd0);
        chk("rst_mc", mispredict_count, 32'd0);

        foreach (vq[i]) run(vq[i], i);

        // Wrong-path EX instruction during the redirect cycle must be ignored.
        drive(1, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
        fetch_pc = 32'h100;
        #1 chk("same_cycle_pt", 32'(pred_taken), 32'd0);
        sb.push_back(32'h80);
        @(negedge clk);
        chk("wp_rv", 32'(redirect_valid), 32'd1);
        chk("wp_bc", branch_count, 32'd19);
        drive(1, 1, 0, 32'h200, 1, 32'h400, 0, 32'h204);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("wp_rv2", 32'(redirect_valid), 32'd0);
        chk("wp_rpc_hold", redirect_pc, 32'h80);
        chk("wp_bc2", branch_count, 32'd19);
        chk("wp_mc2", mispredict_count, 32'd11);
        fetch_pc = 32'h200;
        #1 chk("wp_no_alloc", 32'(pred_taken), 32'd0);
        fetch_pc = 32'h100;
        #1 chk("wp_alloc", 32'(pred_taken), 32'd1);

        // Reset asserted while a redirect is in flight.
        @(negedge clk);
        drive(1, 1, 0, 32'h300, 1, 32'h500, 0, 32'h304);
        sb.push_back(32'h500);
        @(negedge clk);
        chk("rr_rv", 32'(redirect_valid), 32'd1);
        chk("rr_bc", branch_count, 32'd20);
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ex_valid = 1'b0;
        fetch_pc = 32'h300;
        #1;
        chk("rr_rv0", 32'(redirect_valid), 32'd0);
        chk("rr_rpc0", redirect_pc, 32'd0);
        chk("rr_bc0", branch_count, 32'd0);
        chk("rr_mc0", mispredict_count, 32'd0);
        chk("rr_pt0", 32'(pred_taken), 32'd0);
        chk("rr_ptgt", pred_target, 32'h304);

        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
